wave_phase_ctrl: RTL and testbench

Phase-accumulator address generator that sits directly upstream of the four waveform ROMs (sin, square, sawtooth, triangular) and the output mux. It turns debounced key pulses into a frequency index and a waveform selection. It drives the shared 8-bit ROM address and read-enable every cycle. Waveform changes are deferred to the next phase wrap so the output never jumps mid-period.

---
 rtl/wave_phase_ctrl.sv | 111 +++++++++++
 tb/tb_wave_phase_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_phase_ctrl.sv
// Phase-accumulator ROM address generator with key-driven frequency index
// and waveform selection that only changes at a phase wrap.
module wave_phase_ctrl #(
  parameter int PHASE_W  = 24,
  parameter int BASE_FTW = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       freq_up,
  input  logic       freq_down,
  input  logic       wave_next,
  output logic [7:0] rom_addr,
  output logic       rom_rden,
  output logic [1:0] wave_sel,
  output logic [1:0] wave_sel_q,
  output logic [3:0] freq_idx,
  output logic       switch_pending,
  output logic       wrap_strobe
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [PHASE_W-1:0] BASE = PHASE_W'(BASE_FTW);

  logic [1:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W:0]   phase_sum;
  logic [3:0]         freq_q, freq_d;
  logic [1:0]         wave_q, wave_d;
  logic [1:0]         wave_dly_q, wave_dly_d;
  logic               pend_q, pend_d;
  logic               wrap_q, wrap_d;
  logic               advance;
  logic               wrap;

  // (freq_idx + 1) * BASE_FTW, truncated to the accumulator width.
  assign ftw       = BASE * PHASE_W'(freq_q) + BASE;
  assign advance   = en && (state_q != ST_INIT);
  assign phase_sum = {1'b0, phase_q} + {1'b0, ftw};
  assign wrap      = advance && phase_sum[PHASE_W];

  always_comb begin
    phase_d    = advance ? phase_sum[PHASE_W-1:0] : phase_q;
    wrap_d     = wrap;
    wave_dly_d = wave_q;

    freq_d = freq_q;
    if (state_q != ST_INIT) begin
      if (freq_up && !freq_down && freq_q != 4'd15) begin
        freq_d = freq_q + 4'd1;
      end else if (freq_down && !freq_up && freq_q != 4'd0) begin
        freq_d = freq_q - 4'd1;
      end
    end

    state_d = state_q;
    wave_d  = wave_q;
    pend_d  = pend_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (wave_next) begin
          state_d = ST_PEND;
          pend_d  = 1'b1;
        end
      end
      ST_PEND: begin
        // A request arriving on the wrap cycle itself is dropped.
        if (wrap) begin
          state_d = ST_RUN;
          wave_d  = wave_q + 2'd1;
          pend_d  = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      phase_q    <= '0;
      freq_q     <= 4'd0;
      wave_q     <= 2'd0;
      wave_dly_q <= 2'd0;
      pend_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      freq_q     <= freq_d;
      wave_q     <= wave_d;
      wave_dly_q <= wave_dly_d;
      pend_q     <= pend_d;
      wrap_q     <= wrap_d;
    end
  end

  assign rom_addr       = phase_q[PHASE_W-1 -: 8];
  assign rom_rden       = advance;
  assign wave_sel       = wave_q;
  assign wave_sel_q     = wave_dly_q;
  assign freq_idx       = freq_q;
  assign switch_pending = pend_q;
  assign wrap_strobe    = wrap_q;

endmodule

// File: tb/tb_wave_phase_ctrl.sv
// Bench for wave_phase_ctrl: directed scenarios plus a randomized run
// compared against an arithmetic reference model.
module tb_wave_phase_ctrl;

  localparam int    PW  = 24;
  localparam longint MOD = longint'(1) << PW;
  localparam longint BASE = 65536;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       freq_up = 1'b0;
  logic       freq_down = 1'b0;
  logic       wave_next = 1'b0;
  logic [7:0] rom_addr;
  logic       rom_rden;
  logic [1:0] wave_sel;
  logic [1:0] wave_sel_q;
  logic [3:0] freq_idx;
  logic       switch_pending;
  logic       wrap_strobe;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint m_phase = 0;
  int     m_freq = 0;
  int     m_wave = 0;
  int     m_wave_d = 0;
  bit     m_pend = 0;
  bit     m_wrap = 0;
  bit     m_init = 1;

  wave_phase_ctrl #(.PHASE_W(PW), .BASE_FTW(65536)) dut (
    .clk(clk), .rst(rst), .en(en), .freq_up(freq_up), .freq_down(freq_down),
    .wave_next(wave_next), .rom_addr(rom_addr), .rom_rden(rom_rden),
    .wave_sel(wave_sel), .wave_sel_q(wave_sel_q), .freq_idx(freq_idx),
    .switch_pending(switch_pending), .wrap_strobe(wrap_strobe)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    longint ftw;
    bit adv;
    if (rst) begin
      m_phase = 0; m_freq = 0; m_wave = 0; m_wave_d = 0;
      m_pend = 0; m_wrap = 0; m_init = 1;
    end else begin
      ftw = ((m_freq + 1) * BASE) % MOD;
      adv = !m_init && en;
      m_wave_d = m_wave;
      m_wrap = adv && (m_phase + ftw >= MOD);
      if (adv) m_phase = (m_phase + ftw) % MOD;
      if (!m_init) begin
        if (freq_up && !freq_down) m_freq = (m_freq < 15) ? m_freq + 1 : 15;
        else if (freq_down && !freq_up) m_freq = (m_freq > 0) ? m_freq - 1 : 0;
      end
      if (m_pend && m_wrap) begin
        m_wave = (m_wave + 1) % 4;
        m_pend = 0;
      end else if (!m_init && !m_pend && wave_next) begin
        m_pend = 1;
      end
      m_init = 0;
    end
  endtask

  // Inputs only change 1 time unit after the edge, so the model sees the
  // same values the DUT sampled.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1;
    tick(); tick();
    checks++;
    if ({rom_addr, rom_rden, wave_sel, wave_sel_q, freq_idx, switch_pending, wrap_strobe} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0d rden=%0d ws=%0d wsq=%0d f=%0d p=%0d w=%0d, want all 0",
               rom_addr, rom_rden, wave_sel, wave_sel_q, freq_idx, switch_pending, wrap_strobe);
    end
    rst = 0;
    #1;
    checks++;
    if (rom_rden !== 1'b0) begin
      errors++; $display("FAIL init_rden: got %0d want 0", rom_rden);
    end
    tick();
    checks++;
    if (rom_rden !== 1'b1 || rom_addr !== 8'd0) begin
      errors++; $display("FAIL run_start: got rden=%0d addr=%0d want rden=1 addr=0", rom_rden, rom_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_sweep();
    int wraps = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      checks++;
      if (rom_addr !== 8'(i % 256) || wrap_strobe !== (i == 256)) begin
        errors++;
        $display("FAIL sweep_step: cycle %0d got addr=%0d wrap=%0d want addr=%0d wrap=%0d",
                 i, rom_addr, wrap_strobe, i % 256, i == 256);
      end
      if (wrap_strobe) wraps++;
    end
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL sweep_wraps: got %0d want 1", wraps);
    end
    $display("test_sweep done: %0d wraps in 256 cycles", wraps);
  endtask

  task automatic test_freq_ctrl();
    logic [7:0] a;
    for (int i = 0; i < 3; i++) begin
      freq_up = 1; tick(); freq_up = 0; tick();
    end
    checks++;
    if (freq_idx !== 4'd3) begin
      errors++; $display("FAIL freq_up3: got %0d want 3", freq_idx);
    end
    a = rom_addr;
    tick();
    checks++;
    if (rom_addr !== 8'(a + 8'd4)) begin
      errors++; $display("FAIL freq_step4: got %0d want %0d", rom_addr, 8'(a + 8'd4));
    end
    freq_up = 1;
    for (int i = 0; i < 20; i++) tick();
    freq_up = 0;
    checks++;
    if (freq_idx !== 4'd15) begin
      errors++; $display("FAIL freq_sat_hi: got %0d want 15", freq_idx);
    end
    freq_down = 1;
    for (int i = 0; i < 20; i++) tick();
    freq_down = 0;
    checks++;
    if (freq_idx !== 4'd0) begin
      errors++; $display("FAIL freq_sat_lo: got %0d want 0", freq_idx);
    end
    freq_up = 1; tick();
    freq_down = 1; tick();
    freq_up = 0; freq_down = 0;
    checks++;
    if (freq_idx !== 4'd1) begin
      errors++; $display("FAIL freq_both: got %0d want 1", freq_idx);
    end
    freq_down = 1; tick(); freq_down = 0;
    $display("test_freq_ctrl done: freq_idx=%0d", freq_idx);
  endtask

  task automatic test_wave_switch();
    int n = 0;
    int plen = 0;
    while (rom_addr !== 8'd100 && n < 600) begin tick(); n++; end
    checks++;
    if (rom_addr !== 8'd100) begin
      errors++; $display("FAIL reach_100: got %0d want 100", rom_addr);
    end
    wave_next = 1; tick(); wave_next = 0;
    n = 0;
    while (switch_pending === 1'b1 && n < 300) begin
      if (rom_addr == 8'd200) wave_next = 1;
      plen++;
      tick();
      wave_next = 0;
      n++;
    end
    checks++;
    if (plen != 155) begin
      errors++; $display("FAIL pend_len: got %0d want 155", plen);
    end
    checks++;
    if (rom_addr !== 8'd0 || wave_sel !== 2'd1 || wrap_strobe !== 1'b1 || wave_sel_q !== 2'd0) begin
      errors++;
      $display("FAIL switch_edge: got addr=%0d ws=%0d wrap=%0d wsq=%0d want 0 1 1 0",
               rom_addr, wave_sel, wrap_strobe, wave_sel_q);
    end
    tick();
    checks++;
    if (wave_sel_q !== 2'd1) begin
      errors++; $display("FAIL wave_sel_q_delay: got %0d want 1", wave_sel_q);
    end
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (wave_sel !== 2'd1 || switch_pending !== 1'b0) begin
      errors++; $display("FAIL no_queue: got ws=%0d p=%0d want ws=1 p=0", wave_sel, switch_pending);
    end
    $display("test_wave_switch done: pending for %0d cycles", plen);
  endtask

  task automatic do_switch(input int expect_ws);
    int n = 0;
    wave_next = 1; tick(); wave_next = 0;
    while (!(wrap_strobe === 1'b1 && switch_pending === 1'b0) && n < 300) begin tick(); n++; end
    checks++;
    if (wave_sel !== 2'(expect_ws)) begin
      errors++; $display("FAIL switch_seq: got %0d want %0d", wave_sel, expect_ws);
    end
  endtask

  task automatic set_freq(input int f);
    int n = 0;
    while (int'(freq_idx) != f && n < 20) begin
      freq_up = (int'(freq_idx) < f); freq_down = (int'(freq_idx) > f);
      tick(); n++;
    end
    freq_up = 0; freq_down = 0;
  endtask

  task automatic test_wave_seq();
    set_freq(15);
    do_switch(2);
    do_switch(3);
    for (int i = 0; i < 4; i++) do_switch((i + 4) % 4);
    $display("test_wave_seq done: wave_sel=%0d", wave_sel);
  endtask

  task automatic test_enable();
    int n = 0;
    set_freq(0);
    while (rom_addr !== 8'd50 && n < 600) begin tick(); n++; end
    en = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      freq_up = (i == 3); freq_down = (i == 6);
      checks++;
      if (rom_addr !== 8'd50 || rom_rden !== 1'b0 || wrap_strobe !== 1'b0) begin
        errors++;
        $display("FAIL en_hold: got addr=%0d rden=%0d wrap=%0d want 50 0 0", rom_addr, rom_rden, wrap_strobe);
      end
      tick();
      freq_up = 0; freq_down = 0;
      if (i == 3) begin
        checks++;
        if (freq_idx !== 4'd1) begin
          errors++; $display("FAIL en_freq: got %0d want 1", freq_idx);
        end
      end
    end
    en = 1;
    tick();
    checks++;
    if (rom_addr !== 8'd51) begin
      errors++; $display("FAIL en_resume: got %0d want 51", rom_addr);
    end
    $display("test_enable done");
  endtask

  task automatic test_reset_pending();
    int n = 0;
    set_freq(15);
    do_switch(0); do_switch(1); do_switch(2);
    set_freq(7);
    wave_next = 1; tick(); wave_next = 0;
    while (!(switch_pending === 1'b1 && rom_addr >= 8'd160) && n < 100) begin tick(); n++; end
    checks++;
    if (switch_pending !== 1'b1 || wave_sel !== 2'd2 || freq_idx !== 4'd7) begin
      errors++;
      $display("FAIL pre_reset: got p=%0d ws=%0d f=%0d want 1 2 7", switch_pending, wave_sel, freq_idx);
    end
    rst = 1; tick(); rst = 0;
    checks++;
    if ({rom_addr, rom_rden, wave_sel, wave_sel_q, freq_idx, switch_pending, wrap_strobe} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset: got addr=%0d rden=%0d ws=%0d wsq=%0d f=%0d p=%0d w=%0d want all 0",
               rom_addr, rom_rden, wave_sel, wave_sel_q, freq_idx, switch_pending, wrap_strobe);
    end
    tick();
    tick();
    checks++;
    if (rom_addr !== 8'd1 || wave_sel !== 2'd0 || rom_rden !== 1'b1) begin
      errors++; $display("FAIL post_reset: got addr=%0d ws=%0d rden=%0d want 1 0 1", rom_addr, wave_sel, rom_rden);
    end
    $display("test_reset_pending done");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      en        = ($urandom_range(0, 9) != 0);
      freq_up   = ($urandom_range(0, 9) == 0);
      freq_down = ($urandom_range(0, 11) == 0);
      wave_next = ($urandom_range(0, 19) == 0);
      #1;
      checks++;
      if (rom_rden !== (en && !m_init)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_rden: cycle %0d got %0d want %0d", i, rom_rden, en && !m_init);
      end
      tick();
      checks++;
      if (rom_addr !== 8'(m_phase >> (PW - 8)) || wave_sel !== 2'(m_wave) || wave_sel_q !== 2'(m_wave_d) ||
          freq_idx !== 4'(m_freq) || switch_pending !== m_pend || wrap_strobe !== m_wrap) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rand_state: cycle %0d got addr=%0d ws=%0d wsq=%0d f=%0d p=%0d w=%0d want %0d %0d %0d %0d %0d %0d",
                   i, rom_addr, wave_sel, wave_sel_q, freq_idx, switch_pending, wrap_strobe,
                   m_phase >> (PW - 8), m_wave, m_wave_d, m_freq, m_pend, m_wrap);
      end
    end
    rst = 0; freq_up = 0; freq_down = 0; wave_next = 0;
    $display("test_random done: %0d bad cycles", bad);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_freq_ctrl();
    test_wave_switch();
    test_wave_seq();
    test_enable();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
